// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared types and sizing helpers for the sync_fifo burst drain
package sync_fifo_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } burst_state_e;

    // Bits needed to hold a beat count from 0 up to burst_len inclusive.
    function automatic int burst_cnt_w(input int burst_len);
        return $clog2(burst_len + 1);
    endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// rtl/stream_skid_buf.sv - 2-entry valid/ready register slice
//
// Ports:
//   clk, rstn             clock, synchronous active-low reset
//   clear                 synchronous flush, drops both entries
//   in_data/valid/ready   upstream side; ready means "not full"
//   out_data/valid/ready  downstream side; out_data is the head entry
module stream_skid_buf #(
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    // Both flags come straight from the occupancy register, so neither side
    // sees a combinational path through the slice.
    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = head;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head <= in_data;
                    else               tail <= in_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                // Simultaneous push and pop is only possible with exactly one
                // entry held (push needs not-full, pop needs not-empty).
                2'b11: head <= in_data;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_burst_drain.sv
// rtl/fifo_burst_drain.sv - drains sync_fifo in fixed bursts through a skid buffer
//
// Optional feature: define BURST_TIMEOUT_EN to flush a partial burst after
// TIMEOUT_CYCLES idle cycles with a non-empty FIFO below BURST_LEN.
//
// Ports:
//   clk, rstn       clock, synchronous active-low reset
//   clear           synchronous flush, same effect as reset
//   in_data/valid   from sync_fifo out_data/out_valid
//   in_ready        to sync_fifo out_ready
//   fifo_count      sync_fifo occupancy
//   out_data/valid  burst words to the sink
//   out_ready       sink accepts the word
//   out_last        final word of the current burst
//   busy            high while a burst is being pulled from the FIFO
module fifo_burst_drain
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 256,
    parameter int BURST_LEN      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        clear,
    input  logic [DATA_WIDTH-1:0]       in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        busy
);

    localparam int FC_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W = burst_cnt_w(BURST_LEN);
    localparam logic [FC_W-1:0]  BURST_LEN_FC  = FC_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] BURST_LEN_CNT = CNT_W'(BURST_LEN);

    burst_state_e     state;
    burst_state_e     state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] len_r;
    logic [CNT_W-1:0] len_next;

    logic                  skid_in_ready;
    logic [DATA_WIDTH:0]   skid_out;
    logic                  full_avail;
    logic                  beat;
    logic                  last_beat;

`ifdef BURST_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_next;
`endif

    assign full_avail = (fifo_count >= BURST_LEN_FC);
    assign in_ready   = (state == BURST) & skid_in_ready;
    assign beat       = in_valid & in_ready;
    assign last_beat  = (cnt == len_r - CNT_W'(1));
    assign busy       = (state == BURST);

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        len_next   = len_r;
`ifdef BURST_TIMEOUT_EN
        timer_next = timer;
`endif
        case (state)
            IDLE: begin
                cnt_next = '0;
                // A full burst wins over a timeout firing in the same cycle.
                if (full_avail) begin
                    state_next = BURST;
                    len_next   = BURST_LEN_CNT;
`ifdef BURST_TIMEOUT_EN
                    timer_next = '0;
                end else if (fifo_count == '0) begin
                    timer_next = '0;
                end else if (timer == TIMEOUT_LAST) begin
                    // fifo_count < BURST_LEN here, so it fits the beat counter.
                    state_next = BURST;
                    len_next   = fifo_count[CNT_W-1:0];
                    timer_next = '0;
                end else begin
                    timer_next = timer + TMR_W'(1);
`endif
                end
            end
            BURST: begin
                // Leaving on the last beat forces one IDLE cycle, so the next
                // decision sees fifo_count after the FIFO has popped.
                if (beat) begin
                    if (last_beat) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            state <= IDLE;
            cnt   <= '0;
            len_r <= '0;
`ifdef BURST_TIMEOUT_EN
            timer <= '0;
`endif
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            len_r <= len_next;
`ifdef BURST_TIMEOUT_EN
            timer <= timer_next;
`endif
        end
    end

    // The last tag rides alongside its data word through the slice.
    stream_skid_buf #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_skid (
        .clk       (clk),
        .rstn      (rstn),
        .clear     (clear),
        .in_data   ({last_beat, in_data}),
        .in_valid  (in_valid & (state == BURST)),
        .in_ready  (skid_in_ready),
        .out_data  (skid_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    assign out_data = skid_out[DATA_WIDTH-1:0];
    assign out_last = skid_out[DATA_WIDTH] & out_valid;

endmodule

// File: tb/tb_fifo_burst_drain.sv
// tb/tb_fifo_burst_drain.sv - directed self-checking bench for fifo_burst_drain
module tb_fifo_burst_drain;

    logic clk = 1'b0;
    logic rstn;
    logic clear;

    // Instance a: BURST_LEN=4; instance b: BURST_LEN=16
    logic [7:0] a_in_data, b_in_data;
    logic       a_in_valid, b_in_valid;
    logic       a_in_ready, b_in_ready;
    logic [4:0] a_fifo_count, b_fifo_count;
    logic [7:0] a_out_data, b_out_data;
    logic       a_out_valid, b_out_valid;
    logic       a_out_ready, b_out_ready;
    logic       a_out_last, b_out_last;
    logic       a_busy, b_busy;

    logic [7:0] aq[$];
    logic [7:0] bq[$];
    logic [8:0] a_got[$];
    logic [8:0] b_got[$];

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         a_beat_cnt = 0;
    logic       a_gap = 1'b0;
    logic       a_ov_seen = 1'b0;
    logic       b_stall = 1'b0;
    logic [7:0] b_hold = 8'h00;
    logic       b_tog = 1'b0;
    logic [31:0] pat = 32'hB5A3_96C7;
    int         n;

    always #5 clk = ~clk;

    fifo_burst_drain #(
        .DATA_WIDTH(8), .FIFO_DEPTH(16), .BURST_LEN(4), .TIMEOUT_CYCLES(8)
    ) dut_a (
        .clk(clk), .rstn(rstn), .clear(clear),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .fifo_count(a_fifo_count),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_last(a_out_last), .busy(a_busy)
    );

    fifo_burst_drain #(
        .DATA_WIDTH(8), .FIFO_DEPTH(16), .BURST_LEN(16), .TIMEOUT_CYCLES(8)
    ) dut_b (
        .clk(clk), .rstn(rstn), .clear(clear),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .fifo_count(b_fifo_count),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_last(b_out_last), .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present the FIFO model's head and count to both DUTs.
    task automatic drive();
        a_in_valid   = (aq.size() != 0);
        a_in_data    = (aq.size() != 0) ? aq[0] : 8'h00;
        a_fifo_count = 5'(aq.size());
        b_in_valid   = (bq.size() != 0);
        b_in_data    = (bq.size() != 0) ? bq[0] : 8'h00;
        b_fifo_count = 5'(bq.size());
        b_out_ready  = b_tog ? pat[cyc % 32] : 1'b1;
    endtask

    // Sample mid-cycle, advance one clock, then update the FIFO models.
    task automatic tick();
        logic a_hs, b_hs;
        #4;
        a_hs = a_in_valid & a_in_ready;
        b_hs = b_in_valid & b_in_ready;
        if (a_beat_cnt == 4 && !a_in_ready) a_gap = 1'b1;
        if (a_hs) a_beat_cnt++;
        if (a_out_valid) a_ov_seen = 1'b1;
        if (a_out_valid & a_out_ready) a_got.push_back({a_out_last, a_out_data});
        if (b_stall) begin
            chk("b_hold_valid", b_out_valid, 1);
            chk("b_hold_data", b_out_data, b_hold);
        end
        b_stall = b_out_valid & ~b_out_ready;
        b_hold  = b_out_data;
        if (b_out_valid & b_out_ready) b_got.push_back({b_out_last, b_out_data});
        @(posedge clk);
        #1;
        if (a_hs) void'(aq.pop_front());
        if (b_hs) void'(bq.pop_front());
        cyc++;
        drive();
    endtask

    task automatic load_a(input logic [7:0] first, input int cnt);
        for (int i = 0; i < cnt; i++) aq.push_back(first + 8'(i));
        drive();
    endtask

    task automatic wait_a(input int want);
        for (int i = 0; i < 60 && a_got.size() < want; i++) tick();
    endtask

    // Expect cnt words first.. in order, last tag every bl-th word.
    task automatic check_a(input string tag, input logic [7:0] first, input int cnt, input int bl);
        chk({tag, "_count"}, a_got.size(), cnt);
        for (int i = 0; i < cnt; i++) begin
            if (i < a_got.size())
                chk(tag, a_got[i], {((i % bl) == bl - 1) ? 1'b1 : 1'b0, first + 8'(i)});
        end
    endtask

    initial begin
        rstn = 1'b0;
        clear = 1'b0;
        a_out_ready = 1'b1;
        drive();
        tick();
        tick();
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_last", a_out_last, 0);
        chk("rst_in_ready", a_in_ready, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_out_data", a_out_data, 0);
        rstn = 1'b1;
        tick();

        // 1: hold off at count 3, burst of 4 once the 4th word lands
        load_a(8'h10, 3);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_hold_in_ready", a_in_ready, 0);
        end
        chk("t1_hold_valid", a_out_valid, 0);
        load_a(8'h13, 1);
        wait_a(4);
        check_a("t1_word", 8'h10, 4, 4);

        // 4: eight words drain as two bursts separated by an idle cycle
        a_got.delete();
        a_beat_cnt = 0;
        a_gap = 1'b0;
        load_a(8'h20, 8);
        wait_a(8);
        check_a("t4_word", 8'h20, 8, 4);
        chk("t4_gap", a_gap, 1);

        // 5: clear after the second beat
        a_got.delete();
        a_beat_cnt = 0;
        load_a(8'h30, 4);
        for (int i = 0; i < 30 && a_beat_cnt < 2; i++) tick();
        chk("t5_beats", a_beat_cnt, 2);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t5_out_valid", a_out_valid, 0);
        chk("t5_busy", a_busy, 0);
        chk("t5_in_ready", a_in_ready, 0);
        chk("t5_out_last", a_out_last, 0);
        aq.delete();
        a_got.delete();
        load_a(8'h40, 4);
        wait_a(4);
        check_a("t5_recover", 8'h40, 4, 4);

        // 6: one-cycle reset mid-burst
        a_got.delete();
        a_beat_cnt = 0;
        load_a(8'h50, 4);
        for (int i = 0; i < 30 && a_beat_cnt < 2; i++) tick();
        chk("t6_beats", a_beat_cnt, 2);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("t6_out_valid", a_out_valid, 0);
        chk("t6_busy", a_busy, 0);
        chk("t6_in_ready", a_in_ready, 0);
        chk("t6_out_last", a_out_last, 0);
        chk("t6_out_data", a_out_data, 0);
        aq.delete();
        a_got.delete();
        load_a(8'h54, 4);
        wait_a(4);
        check_a("t6_recover", 8'h54, 4, 4);

        // 3: 16-word burst on instance b with a stalling sink
        b_tog = 1'b1;
        for (int i = 0; i < 16; i++) bq.push_back(8'h80 + 8'(i));
        drive();
        for (int i = 0; i < 200 && b_got.size() < 16; i++) tick();
        b_tog = 1'b0;
        drive();
        chk("t3_count", b_got.size(), 16);
        for (int i = 0; i < 16; i++) begin
            if (i < b_got.size())
                chk("t3_word", b_got[i], {(i == 15) ? 1'b1 : 1'b0, 8'h80 + 8'(i)});
        end

        // 2: three residual words
        tick();
        a_got.delete();
        a_ov_seen = 1'b0;
        load_a(8'h60, 3);
`ifdef BURST_TIMEOUT_EN
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (a_out_valid) break;
        end
        chk("t2_timeout_latency", n, 9);
        wait_a(3);
        check_a("t2_partial", 8'h60, 3, 3);
`else
        for (int i = 0; i < 2000; i++) tick();
        chk("t2_no_out_valid", a_ov_seen, 0);
        chk("t2_no_words", a_got.size(), 0);
        load_a(8'h63, 1);
        wait_a(4);
        check_a("t2_fill", 8'h60, 4, 4);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
